// File: rtl/ov9281_init_seq_if.sv
// Request/response handshake between the OV9281 init sequencer (master)
// and the ov9281_cfg I2C register-access unit (slave).
interface ov9281_init_seq_if;
    logic        cfg_start;
    logic        cfg_write;
    logic        cfg_read;
    logic [15:0] cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        cfg_busy;
    logic        cfg_valid;
    logic        cfg_error;
    logic [7:0]  cfg_rdata;

    modport master (
        output cfg_start, cfg_write, cfg_read, cfg_addr, cfg_wdata,
        input  cfg_busy, cfg_valid, cfg_error, cfg_rdata
    );

    modport slave (
        input  cfg_start, cfg_write, cfg_read, cfg_addr, cfg_wdata,
        output cfg_busy, cfg_valid, cfg_error, cfg_rdata
    );
endinterface

// File: rtl/ov9281_init_seq.sv
// Power-on register-table walker for the OV9281: one I2C write per entry,
// optional read-back verify with bounded retries, plus delay and end entries.
module ov9281_init_seq #(
    parameter int CLK_FREQ    = 50000000,
    parameter int TABLE_DEPTH = 256,
    parameter int IDX_WIDTH   = 8,
    parameter int MAX_RETRY   = 3,
    parameter bit VERIFY      = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [IDX_WIDTH-1:0] o_err_idx,
    output logic [IDX_WIDTH-1:0] o_tbl_idx,
    input  logic [23:0]          i_tbl_entry,
    ov9281_init_seq_if.master    cfg
);
    localparam int UNIT    = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int DLY_W   = $clog2(255 * UNIT + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(TABLE_DEPTH - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LIM  = RETRY_W'(MAX_RETRY);
    localparam logic [DLY_W-1:0]     UNIT_CNT   = DLY_W'(UNIT);
    localparam logic [15:0]          ADDR_END   = 16'hFFFE;
    localparam logic [15:0]          ADDR_DELAY = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ISSUE_W, WAIT_W, ISSUE_R, WAIT_R, DELAY, NEXT, DONE, FAIL
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [IDX_WIDTH-1:0] err_idx_q, err_idx_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [15:0]          addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 start_q, start_d;
    logic                 write_q, write_d;
    logic                 read_q, read_d;
    logic                 retry_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            err_idx_q <= '0;
            retry_q   <= '0;
            dly_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            start_q   <= 1'b0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            retry_q   <= retry_d;
            dly_q     <= dly_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            start_q   <= start_d;
            write_q   <= write_d;
            read_q    <= read_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        retry_d   = retry_q;
        dly_d     = dly_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        start_d   = 1'b0;
        write_d   = write_q;
        read_d    = read_q;
        retry_req = 1'b0;

        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (i_start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (i_tbl_entry[23:8] == ADDR_END) begin
                    state_d = DONE;
                end else if (i_tbl_entry[23:8] == ADDR_DELAY) begin
                    if (i_tbl_entry[7:0] == 8'h00) begin
                        state_d = NEXT;
                    end else begin
                        dly_d   = DLY_W'(i_tbl_entry[7:0]) * UNIT_CNT;
                        state_d = DELAY;
                    end
                end else begin
                    addr_d  = i_tbl_entry[23:8];
                    wdata_d = i_tbl_entry[7:0];
                    state_d = ISSUE_W;
                end
            end
            // The request pulse is registered, so it appears the cycle after busy is seen low.
            ISSUE_W: begin
                if (!cfg.cfg_busy) begin
                    start_d = 1'b1;
                    write_d = 1'b1;
                    read_d  = 1'b0;
                    state_d = WAIT_W;
                end
            end
            WAIT_W: begin
                if (cfg.cfg_error) begin
                    retry_req = 1'b1;
                end else if (cfg.cfg_valid) begin
                    write_d = 1'b0;
                    state_d = VERIFY ? ISSUE_R : NEXT;
                end
            end
            ISSUE_R: begin
                if (!cfg.cfg_busy) begin
                    start_d = 1'b1;
                    write_d = 1'b0;
                    read_d  = 1'b1;
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (cfg.cfg_error) begin
                    retry_req = 1'b1;
                end else if (cfg.cfg_valid) begin
                    if (cfg.cfg_rdata == wdata_q) begin
                        read_d  = 1'b0;
                        state_d = NEXT;
                    end else begin
                        retry_req = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (dly_q <= DLY_W'(1)) begin
                    dly_d   = '0;
                    state_d = NEXT;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            NEXT: begin
                retry_d = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_WIDTH'(1);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // A failed write, failed read or read-back mismatch all rewrite the same entry.
        if (retry_req) begin
            write_d = 1'b0;
            read_d  = 1'b0;
            if (retry_q < RETRY_LIM) begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = ISSUE_W;
            end else begin
                err_idx_d = idx_q;
                state_d   = FAIL;
            end
        end
    end

    assign o_busy    = (state_q != IDLE) && (state_q != DONE) && (state_q != FAIL);
    assign o_done    = (state_q == DONE);
    assign o_error   = (state_q == FAIL);
    assign o_err_idx = err_idx_q;
    assign o_tbl_idx = idx_q;

    assign cfg.cfg_start = start_q;
    assign cfg.cfg_write = write_q;
    assign cfg.cfg_read  = read_q;
    assign cfg.cfg_addr  = addr_q;
    assign cfg.cfg_wdata = wdata_q;
endmodule

// File: tb/tb_ov9281_init_seq.sv
// Self-checking bench for ov9281_init_seq: a verify and a no-verify instance,
// each with a behavioural cfg responder, against a transaction-level table model.
module tb_ov9281_init_seq;
    localparam int CLK_FREQ = 4000;
    localparam int UNIT     = CLK_FREQ / 1000;
    localparam int DEPTH    = 8;
    localparam int IW       = 3;
    localparam int MAXR     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0] tbl [DEPTH];

    logic          start_v = 1'b0;
    logic          busy_v, done_v, error_v;
    logic [IW-1:0] err_idx_v, tbl_idx_v;
    logic [23:0]   entry_v;
    ov9281_init_seq_if cfg_v ();

    ov9281_init_seq #(
        .CLK_FREQ(CLK_FREQ), .TABLE_DEPTH(DEPTH), .IDX_WIDTH(IW), .MAX_RETRY(MAXR), .VERIFY(1'b1)
    ) u_dut_v (
        .i_clk(clk), .i_rst(rst), .i_start(start_v),
        .o_busy(busy_v), .o_done(done_v), .o_error(error_v),
        .o_err_idx(err_idx_v), .o_tbl_idx(tbl_idx_v), .i_tbl_entry(entry_v),
        .cfg(cfg_v)
    );

    logic          start_nv = 1'b0;
    logic          busy_nv, done_nv, error_nv;
    logic [IW-1:0] err_idx_nv, tbl_idx_nv;
    logic [23:0]   entry_nv;
    ov9281_init_seq_if cfg_nv ();

    ov9281_init_seq #(
        .CLK_FREQ(CLK_FREQ), .TABLE_DEPTH(DEPTH), .IDX_WIDTH(IW), .MAX_RETRY(MAXR), .VERIFY(1'b0)
    ) u_dut_nv (
        .i_clk(clk), .i_rst(rst), .i_start(start_nv),
        .o_busy(busy_nv), .o_done(done_nv), .o_error(error_nv),
        .o_err_idx(err_idx_nv), .o_tbl_idx(tbl_idx_nv), .i_tbl_entry(entry_nv),
        .cfg(cfg_nv)
    );

    always @(posedge clk) begin
        entry_v  <= tbl[tbl_idx_v];
        entry_nv <= tbl[tbl_idx_nv];
    end

    // cfg responder: fixed latency, injects write errors and read corruption on request.
    logic [7:0]  mem [logic [15:0]];
    int          err_writes = 0;
    bit          corrupt    = 1'b0;
    int          lat        = 1;
    bit          force_busy = 1'b0;
    bit          m_busy = 1'b0, m_pend = 1'b0, m_isw = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    int          start_while_busy = 0;
    logic [25:0] act_log [$];

    assign cfg_v.cfg_busy = m_busy | force_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend          <= 1'b0;
            m_busy          <= 1'b0;
            cfg_v.cfg_valid <= 1'b0;
            cfg_v.cfg_error <= 1'b0;
            cfg_v.cfg_rdata <= 8'h00;
        end else begin
            cfg_v.cfg_valid <= 1'b0;
            cfg_v.cfg_error <= 1'b0;
            if (cfg_v.cfg_start) begin
                if (cfg_v.cfg_busy) start_while_busy <= start_while_busy + 1;
                act_log.push_back({cfg_v.cfg_write, cfg_v.cfg_read, cfg_v.cfg_addr,
                                   cfg_v.cfg_write ? cfg_v.cfg_wdata : 8'h00});
                m_pend  <= 1'b1;
                m_isw   <= cfg_v.cfg_write;
                m_addr  <= cfg_v.cfg_addr;
                m_wdata <= cfg_v.cfg_wdata;
                m_cnt   <= lat;
                m_busy  <= 1'b1;
            end else if (m_pend) begin
                if (m_cnt > 1) begin
                    m_cnt <= m_cnt - 1;
                end else begin
                    m_pend <= 1'b0;
                    m_busy <= 1'b0;
                    if (m_isw) begin
                        if (err_writes > 0) begin
                            err_writes      <= err_writes - 1;
                            cfg_v.cfg_error <= 1'b1;
                        end else begin
                            mem[m_addr]      = m_wdata;
                            cfg_v.cfg_valid <= 1'b1;
                        end
                    end else begin
                        cfg_v.cfg_rdata <= (mem.exists(m_addr) ? mem[m_addr] : 8'h00) ^ {7'd0, corrupt};
                        cfg_v.cfg_valid <= 1'b1;
                    end
                end
            end
        end
    end

    logic [25:0] nv_log [$];
    bit          nv_pend = 1'b0;
    int          nv_cnt  = 0;
    assign cfg_nv.cfg_error = 1'b0;
    assign cfg_nv.cfg_rdata = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            nv_pend          <= 1'b0;
            cfg_nv.cfg_busy  <= 1'b0;
            cfg_nv.cfg_valid <= 1'b0;
        end else begin
            cfg_nv.cfg_valid <= 1'b0;
            if (cfg_nv.cfg_start) begin
                nv_log.push_back({cfg_nv.cfg_write, cfg_nv.cfg_read, cfg_nv.cfg_addr,
                                  cfg_nv.cfg_write ? cfg_nv.cfg_wdata : 8'h00});
                nv_pend         <= 1'b1;
                nv_cnt          <= 2;
                cfg_nv.cfg_busy <= 1'b1;
            end else if (nv_pend) begin
                if (nv_cnt > 1) begin
                    nv_cnt <= nv_cnt - 1;
                end else begin
                    nv_pend          <= 1'b0;
                    cfg_nv.cfg_busy  <= 1'b0;
                    cfg_nv.cfg_valid <= 1'b1;
                end
            end
        end
    end

    logic [25:0] exp_log [$];
    bit          exp_done, exp_error;
    int          exp_err_idx;
    int          busy_cycles;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Walks the table as a list of transactions: each write entry gets up to MAXR+1 attempts.
    task automatic model_run(input bit verify, input int errw, input bit corr);
        exp_log.delete();
        exp_done    = 1'b0;
        exp_error   = 1'b0;
        exp_err_idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            bit          ok;
            a  = tbl[i][23:8];
            d  = tbl[i][7:0];
            ok = 1'b0;
            if (a == 16'hFFFE) begin
                exp_done = 1'b1;
                return;
            end
            if (a != 16'hFFFF) begin
                for (int k = 0; k <= MAXR && !ok; k++) begin
                    exp_log.push_back({2'b10, a, d});
                    if (errw > 0) begin
                        errw--;
                    end else if (!verify) begin
                        ok = 1'b1;
                    end else begin
                        exp_log.push_back({2'b01, a, 8'h00});
                        ok = !corr;
                    end
                end
                if (!ok) begin
                    exp_error   = 1'b1;
                    exp_err_idx = i;
                    return;
                end
            end
        end
        exp_done = 1'b1;
    endtask

    task automatic apply_stimulus(input int errw, input bit corr, input int latency);
        model_run(1'b1, errw, corr);
        err_writes = errw;
        corrupt    = corr;
        lat        = latency;
        act_log.delete();
        start_while_busy = 0;
        @(negedge clk);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
    endtask

    task automatic wait_end_v(input string tag, input int budget);
        int n;
        n = 0;
        busy_cycles = 0;
        while (!(done_v || error_v) && n < budget) begin
            if (busy_v) busy_cycles++;
            @(negedge clk);
            n++;
        end
        check_output({tag, "_finished"}, 32'(n < budget), 1);
    endtask

    task automatic compare_v(input string tag);
        check_output({tag, "_done"}, done_v, 32'(exp_done));
        check_output({tag, "_error"}, error_v, 32'(exp_error));
        check_output({tag, "_busy"}, busy_v, 0);
        if (exp_error) check_output({tag, "_err_idx"}, err_idx_v, exp_err_idx);
        check_output({tag, "_txn_count"}, act_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < act_log.size(); i++)
            check_output($sformatf("%s_txn%0d", tag, i), act_log[i], exp_log[i]);
        check_output({tag, "_start_while_busy"}, start_while_busy, 0);
    endtask

    task automatic set_basic_table();
        for (int i = 0; i < DEPTH; i++) tbl[i] = {16'hFFFE, 8'h00};
        tbl[0] = {16'h0100, 8'h01};
        tbl[1] = {16'h3501, 8'h40};
    endtask

    initial begin
        int n;
        int exp_b;
        set_basic_table();
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_busy", busy_v, 0);
        check_output("rst_done", done_v, 0);
        check_output("rst_error", error_v, 0);
        check_output("rst_tbl_idx", tbl_idx_v, 0);
        check_output("rst_err_idx", err_idx_v, 0);
        check_output("rst_cfg_start", cfg_v.cfg_start, 0);
        check_output("rst_cfg_write", cfg_v.cfg_write, 0);
        check_output("rst_cfg_read", cfg_v.cfg_read, 0);
        check_output("rst_cfg_addr", cfg_v.cfg_addr, 0);
        check_output("rst_cfg_wdata", cfg_v.cfg_wdata, 0);
        check_output("rst_nv_busy", busy_nv, 0);
        rst = 1'b0;

        // No-verify instance: writes only.
        model_run(1'b0, 0, 1'b0);
        nv_log.delete();
        @(negedge clk);
        start_nv = 1'b1;
        @(negedge clk);
        start_nv = 1'b0;
        n = 0;
        while (!(done_nv || error_nv) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_output("nv_finished", 32'(n < 1000), 1);
        check_output("nv_done", done_nv, 1);
        check_output("nv_busy", busy_nv, 0);
        check_output("nv_txn_count", nv_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < nv_log.size(); i++)
            check_output($sformatf("nv_txn%0d", i), nv_log[i], exp_log[i]);

        apply_stimulus(0, 1'b0, 2);
        wait_end_v("verify_ok", 3000);
        compare_v("verify_ok");

        tbl[0] = {16'h3501, 8'h40};
        tbl[1] = {16'hFFFE, 8'h00};
        apply_stimulus(0, 1'b1, 2);
        wait_end_v("verify_bad", 3000);
        compare_v("verify_bad");

        set_basic_table();
        apply_stimulus(1, 1'b0, 1);
        wait_end_v("retry_once", 3000);
        compare_v("retry_once");

        apply_stimulus(6, 1'b0, 1);
        wait_end_v("retry_cleared", 3000);
        compare_v("retry_cleared");

        tbl[0] = {16'hFFFF, 8'h03};
        tbl[1] = {16'hFFFE, 8'h00};
        apply_stimulus(0, 1'b0, 1);
        wait_end_v("delay3", 3000);
        check_output("delay3_busy_cycles", busy_cycles, 2 + 3 + 3 * UNIT);
        compare_v("delay3");

        tbl[0] = {16'hFFFF, 8'h00};
        apply_stimulus(0, 1'b0, 1);
        wait_end_v("delay0", 3000);
        check_output("delay0_busy_cycles", busy_cycles, 5);
        compare_v("delay0");

        for (int t = 0; t < 3; t++) begin
            int cnt;
            cnt   = $urandom_range(1, 3);
            exp_b = 2;
            for (int i = 0; i < cnt; i++) begin
                int d;
                d      = $urandom_range(0, 4);
                tbl[i] = {16'hFFFF, 8'(d)};
                exp_b += 3 + d * UNIT;
            end
            tbl[cnt] = {16'hFFFE, 8'h00};
            apply_stimulus(0, 1'b0, 1);
            wait_end_v($sformatf("rdelay%0d", t), 3000);
            check_output($sformatf("rdelay%0d_busy_cycles", t), busy_cycles, exp_b);
        end

        for (int i = 0; i < DEPTH; i++) tbl[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
        apply_stimulus($urandom_range(0, 2), 1'b0, $urandom_range(1, 4));
        wait_end_v("implicit_end", 5000);
        compare_v("implicit_end");

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int kind;
                kind = $urandom_range(0, 9);
                if (kind == 0)      tbl[i] = {16'hFFFE, 8'h00};
                else if (kind <= 2) tbl[i] = {16'hFFFF, 8'($urandom_range(0, 2))};
                else                tbl[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
            end
            apply_stimulus($urandom_range(0, 5), ($urandom_range(0, 4) == 0), $urandom_range(1, 4));
            wait_end_v($sformatf("rand%0d", t), 5000);
            compare_v($sformatf("rand%0d", t));
        end

        // Reset while entry 1's write is outstanding.
        set_basic_table();
        apply_stimulus(0, 1'b0, 4);
        n = 0;
        while (act_log.size() < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output("midrst_reached", 32'(n < 500), 1);
        rst = 1'b1;
        #1;
        check_output("midrst_busy", busy_v, 0);
        check_output("midrst_done", done_v, 0);
        check_output("midrst_error", error_v, 0);
        check_output("midrst_tbl_idx", tbl_idx_v, 0);
        check_output("midrst_err_idx", err_idx_v, 0);
        check_output("midrst_cfg_start", cfg_v.cfg_start, 0);
        check_output("midrst_cfg_write", cfg_v.cfg_write, 0);
        check_output("midrst_cfg_read", cfg_v.cfg_read, 0);
        check_output("midrst_cfg_addr", cfg_v.cfg_addr, 0);
        check_output("midrst_cfg_wdata", cfg_v.cfg_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(0, 1'b0, 2);
        check_output("restart_tbl_idx", tbl_idx_v, 0);
        wait_end_v("restart", 3000);
        compare_v("restart");

        // Busy held before the first issue, then a stray start mid-sequence.
        force_busy = 1'b1;
        apply_stimulus(0, 1'b0, 2);
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("busy_hold%0d_start", k), cfg_v.cfg_start, 0);
            @(negedge clk);
        end
        force_busy = 1'b0;
        check_output("busy_drop_start", cfg_v.cfg_start, 0);
        @(negedge clk);
        check_output("busy_after_start", cfg_v.cfg_start, 1);
        n = 0;
        while (act_log.size() < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output("stray_reached", 32'(n < 500), 1);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        check_output("stray_tbl_idx", tbl_idx_v, 1);
        wait_end_v("stray", 3000);
        compare_v("stray");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ov9281_init_seq.md
Name: ov9281_init_seq

Overview:
- Sequencer that brings up the OV9281 after power-on by walking a register table and issuing one I2C register write per entry through the configuration unit (ov9281_cfg).
- Table entries can also request a millisecond delay or end the table.
- With VERIFY=1, each write is read back and compared.
- Sits between the top-level start control and the cfg unit's start/read/write handshake.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz; one delay unit lasts CLK_FREQ/1000 cycles.
- TABLE_DEPTH, 256, number of table entries.
- IDX_WIDTH, 8, width of the table index; must be at least clog2(TABLE_DEPTH).
- MAX_RETRY, 3, retries per entry after the first failed attempt.
- VERIFY, 1, 1 = read back each write and compare.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  single-cycle pulse that starts the sequence.
- o_busy  out  1  high from accepted start until DONE or FAIL.
- o_done  out  1  high while in DONE.
- o_error  out  1  high while in FAIL.
- o_err_idx  out  IDX_WIDTH  index of the failing entry.
- o_tbl_idx  out  IDX_WIDTH  table read address.
- i_tbl_entry  in  24  {addr[23:8], data[7:0]}; valid one cycle after o_tbl_idx changes (sync ROM).
- o_cfg_start  out  1  one-cycle request pulse to the cfg unit.
- o_cfg_write  out  1  write qualifier, held with the request.
- o_cfg_read  out  1  read qualifier, held with the request.
- o_cfg_addr  out  16  register address.
- o_cfg_wdata  out  8  register write data.
- i_cfg_busy  in  1  cfg unit transaction in progress.
- i_cfg_valid  in  1  one-cycle pulse when a transaction completes successfully.
- i_cfg_error  in  1  one-cycle pulse on NACK or timeout.
- i_cfg_rdata  in  8  read data, valid with i_cfg_valid.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - All outputs 0: o_busy, o_done, o_error, o_err_idx, o_tbl_idx, o_cfg_start, o_cfg_write, o_cfg_read, o_cfg_addr, o_cfg_wdata.
  - Retry and delay counters 0.
  - Reset mid-transaction abandons the sequence; nothing is resumed.
- States: IDLE, FETCH, DECODE, ISSUE_W, WAIT_W, ISSUE_R, WAIT_R, DELAY, NEXT, DONE, FAIL.
- IDLE, DONE, FAIL:
  - i_start -> FETCH, with idx=0, retry=0, o_done=0, o_error=0.
  - i_start in any other state is ignored.
- FETCH: drive o_tbl_idx=idx; next cycle go to DECODE.
- DECODE (entry is sampled here):
  - addr=0xFFFE -> DONE (end marker).
  - addr=0xFFFF -> DELAY; load count = data*(CLK_FREQ/1000). data=0 -> NEXT directly.
  - Any other addr -> ISSUE_W; latch o_cfg_addr and o_cfg_wdata.
- ISSUE_W:
  - Wait until i_cfg_busy=0.
  - Then pulse o_cfg_start for exactly 1 cycle with o_cfg_write=1, o_cfg_read=0, and go to WAIT_W.
  - o_cfg_addr and o_cfg_wdata stay stable until the transaction completes.
- WAIT_W:
  - i_cfg_valid -> ISSUE_R if VERIFY=1, else NEXT.
  - i_cfg_error -> retry path.
  - If both arrive in the same cycle, error wins.
- ISSUE_R / WAIT_R:
  - Same handshake as the write, with o_cfg_read=1, o_cfg_write=0.
  - On i_cfg_valid: i_cfg_rdata == latched wdata -> NEXT; mismatch -> retry path.
  - i_cfg_error -> retry path.
- Retry path:
  - retry<MAX_RETRY -> retry+1, back to ISSUE_W (rewrite the same entry).
  - Otherwise -> FAIL with o_err_idx=idx.
- DELAY: decrement the count every cycle; at 1 go to NEXT. A delay of N units takes exactly N*(CLK_FREQ/1000) cycles in DELAY.
- NEXT:
  - retry=0.
  - idx=TABLE_DEPTH-1 -> DONE (implicit end; no wrap).
  - Otherwise idx+1 -> FETCH.
- Status outputs:
  - o_busy=1 in every state except IDLE, DONE, FAIL.
  - o_done and o_error are levels; they clear on the next accepted i_start.
- Width rules:
  - Delay counter sized for 255*(CLK_FREQ/1000).
  - Retry counter holds values 0..MAX_RETRY.
- o_cfg_start is never asserted while i_cfg_busy=1.

Test Plan:
- Table {0x0100/0x01, 0x3501/0x40, 0xFFFE}, VERIFY=0, cfg model always valid -> exactly 2 write pulses with addr/data 0x0100/0x01 then 0x3501/0x40; o_done=1, o_busy=0; no read pulses.
- CLK_FREQ=4000, table {0xFFFF/0x03, 0xFFFE} -> DELAY lasts exactly 12 cycles; o_done follows. Entry 0xFFFF/0x00 -> no cycles spent in DELAY.
- VERIFY=1, the model returns 0x40 for a write of 0x40 -> write then read per entry, then DONE. The model returns 0x41 on every read -> 4 write+read attempts (MAX_RETRY=3), then o_error=1, o_err_idx=0.
- i_cfg_error on the first write only -> one retry write of the same addr/data; the sequence completes with o_done=1 and the retry counter is cleared for the next entry.
- Assert i_rst during WAIT_W of entry 1 -> all outputs 0 immediately (async). A new i_start restarts from idx 0 with o_tbl_idx=0.
- Hold i_cfg_busy=1 for 5 cycles before an issue -> o_cfg_start is not asserted until the cycle after busy drops. An i_start pulse mid-sequence does not change idx.
